// File: rtl/udma_i2c_mux.sv
// Round-robin arbiter that locks one of NUM_CH uDMA byte streams onto a single I2C engine per bus transaction.
// Optional stall watchdog (sticky err_o, abort_o pulse) is built only when UDMA_I2C_MUX_TIMEOUT_EN is defined.
module udma_i2c_mux #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CH-1:0]              ch_en_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_tx_data_i,
  input  logic [NUM_CH-1:0]              ch_tx_last_i,
  input  logic [NUM_CH-1:0]              ch_tx_valid_i,
  output logic [NUM_CH-1:0]              ch_tx_ready_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]   ch_rx_data_o,
  output logic [NUM_CH-1:0]              ch_rx_valid_o,
  input  logic [NUM_CH-1:0]              ch_rx_ready_i,
  output logic [DATA_WIDTH-1:0]          ctrl_tx_data_o,
  output logic                           ctrl_tx_valid_o,
  input  logic                           ctrl_tx_ready_i,
  input  logic [DATA_WIDTH-1:0]          ctrl_rx_data_i,
  input  logic                           ctrl_rx_valid_i,
  output logic                           ctrl_rx_ready_o,
  input  logic                           ctrl_idle_i,
  input  logic [TIMEOUT_W-1:0]           timeout_cfg_i,
  input  logic [NUM_CH-1:0]              err_clr_i,
  output logic [$clog2(NUM_CH)-1:0]      owner_o,
  output logic                           busy_o,
  output logic [NUM_CH-1:0]              err_o,
  output logic                           abort_o
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       owner_q, owner_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0]     req_s;
  logic                  req_found_s;
  logic [CH_W-1:0]       winner_s;
  logic [CH_W:0]         cand_s;

  logic                  own_valid_s;
  logic                  own_last_s;
  logic                  own_rx_ready_s;
  logic [DATA_WIDTH-1:0] own_data_s;
  logic                  own_hs_s;
  logic                  timeout_hit_s;

  // Select the current owner's TX word and RX ready without variable-width indexing
  always_comb begin
    own_valid_s    = 1'b0;
    own_last_s     = 1'b0;
    own_rx_ready_s = 1'b0;
    own_data_s     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (owner_q == CH_W'(k)) begin
        own_valid_s    = ch_tx_valid_i[k];
        own_last_s     = ch_tx_last_i[k];
        own_rx_ready_s = ch_rx_ready_i[k];
        own_data_s     = ch_tx_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        own_valid_s    = own_valid_s;
      end
    end
  end

  assign own_hs_s = (state_q == ST_XFER) && own_valid_s && ctrl_tx_ready_i;

  // Round-robin search starting at rr_ptr, wrapping past NUM_CH-1
  always_comb begin
    req_s       = ch_en_i & ch_tx_valid_i;
    req_found_s = 1'b0;
    winner_s    = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (cand_s >= (CH_W+1)'(NUM_CH)) begin
        cand_s = cand_s - (CH_W+1)'(NUM_CH);
      end else begin
        cand_s = cand_s;
      end
      if (!req_found_s && req_s[cand_s[CH_W-1:0]]) begin
        req_found_s = 1'b1;
        winner_s    = cand_s[CH_W-1:0];
      end else begin
        winner_s    = winner_s;
      end
    end
  end

  // Transaction FSM next-state: grant lock held until the engine reports idle
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_found_s) begin
          owner_d = winner_s;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (own_hs_s && own_last_s) begin
          state_d = ST_DRAIN;
        end else if (timeout_hit_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (ctrl_idle_i) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (owner_q == CH_W'(NUM_CH-1)) ? '0 : owner_q + CH_W'(1);
        end else begin
          state_d  = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, owner and round-robin pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Datapath steering: TX only in XFER, RX routed to owner while a transaction is open
  always_comb begin
    ch_tx_ready_o   = '0;
    ch_rx_data_o    = '0;
    ch_rx_valid_o   = '0;
    ctrl_tx_data_o  = '0;
    ctrl_tx_valid_o = 1'b0;
    ctrl_rx_ready_o = 1'b1;
    if (state_q == ST_XFER) begin
      ctrl_tx_data_o  = own_data_s;
      ctrl_tx_valid_o = own_valid_s;
    end else begin
      ctrl_tx_valid_o = 1'b0;
    end
    if (state_q != ST_IDLE) begin
      ctrl_rx_ready_o = own_rx_ready_s;
    end else begin
      ctrl_rx_ready_o = 1'b1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if ((owner_q == CH_W'(k)) && (state_q != ST_IDLE)) begin
        ch_tx_ready_o[k]                         = (state_q == ST_XFER) ? ctrl_tx_ready_i : 1'b0;
        ch_rx_data_o[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_rx_data_i;
        ch_rx_valid_o[k]                         = ctrl_rx_valid_i;
      end else begin
        ch_tx_ready_o[k] = 1'b0;
      end
    end
  end

  assign owner_o = owner_q;
  assign busy_o  = (state_q != ST_IDLE);

`ifdef UDMA_I2C_MUX_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NUM_CH-1:0]    err_q, err_d;
  logic                 abort_q, abort_d;

  // Stall counter runs only in XFER; it is zero on entry because IDLE holds it cleared
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == ST_XFER) && !own_valid_s) begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    end else begin
      tmo_cnt_d = '0;
    end
  end

  assign timeout_hit_s = (state_q == ST_XFER) && !own_valid_s &&
                         (timeout_cfg_i != '0) && (tmo_cnt_d == timeout_cfg_i);

  // Sticky error: a timeout in the same cycle overrides a clear request
  always_comb begin
    err_d   = err_q & ~err_clr_i;
    abort_d = 1'b0;
    if (timeout_hit_s) begin
      abort_d = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (owner_q == CH_W'(k)) begin
          err_d[k] = 1'b1;
        end else begin
          err_d[k] = err_d[k];
        end
      end
    end else begin
      abort_d = 1'b0;
    end
  end

  // Watchdog state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      err_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
    end
  end

  assign err_o   = err_q;
  assign abort_o = abort_q;
`else
  logic unused_tmo_s;

  assign timeout_hit_s = 1'b0;
  assign err_o         = '0;
  assign abort_o       = 1'b0;
  assign unused_tmo_s  = ^{timeout_cfg_i, err_clr_i};
`endif

endmodule

// File: tb/tb_udma_i2c_mux.sv
// Directed bench for udma_i2c_mux: per-channel word sources, scoreboard queues for engine-side TX and channel-side RX.
module tb_udma_i2c_mux;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int TW  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH-1:0]    ch_en_i;
  logic [NCH*DW-1:0] ch_tx_data_i;
  logic [NCH-1:0]    ch_tx_last_i;
  logic [NCH-1:0]    ch_tx_valid_i;
  logic [NCH-1:0]    ch_tx_ready_o;
  logic [NCH*DW-1:0] ch_rx_data_o;
  logic [NCH-1:0]    ch_rx_valid_o;
  logic [NCH-1:0]    ch_rx_ready_i;
  logic [DW-1:0]     ctrl_tx_data_o;
  logic              ctrl_tx_valid_o;
  logic              ctrl_tx_ready_i;
  logic [DW-1:0]     ctrl_rx_data_i;
  logic              ctrl_rx_valid_i;
  logic              ctrl_rx_ready_o;
  logic              ctrl_idle_i;
  logic [TW-1:0]     timeout_cfg_i;
  logic [NCH-1:0]    err_clr_i;
  logic [1:0]        owner_o;
  logic              busy_o;
  logic [NCH-1:0]    err_o;
  logic              abort_o;

  udma_i2c_mux #(.NUM_CH(NCH), .DATA_WIDTH(DW), .TIMEOUT_W(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_en_i(ch_en_i),
    .ch_tx_data_i(ch_tx_data_i), .ch_tx_last_i(ch_tx_last_i),
    .ch_tx_valid_i(ch_tx_valid_i), .ch_tx_ready_o(ch_tx_ready_o),
    .ch_rx_data_o(ch_rx_data_o), .ch_rx_valid_o(ch_rx_valid_o),
    .ch_rx_ready_i(ch_rx_ready_i), .ctrl_tx_data_o(ctrl_tx_data_o),
    .ctrl_tx_valid_o(ctrl_tx_valid_o), .ctrl_tx_ready_i(ctrl_tx_ready_i),
    .ctrl_rx_data_i(ctrl_rx_data_i), .ctrl_rx_valid_i(ctrl_rx_valid_i),
    .ctrl_rx_ready_o(ctrl_rx_ready_o), .ctrl_idle_i(ctrl_idle_i),
    .timeout_cfg_i(timeout_cfg_i), .err_clr_i(err_clr_i),
    .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o), .abort_o(abort_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] rx_exp_q[$];

  logic [7:0] src_data [NCH][16];
  logic       src_last [NCH][16];
  int         src_len  [NCH];
  int         src_idx  [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_src();
    for (int k = 0; k < NCH; k++) begin
      src_len[k] = 0;
      src_idx[k] = 0;
    end
  endtask

  task automatic add_word(input int k, input logic [7:0] d, input logic l);
    src_data[k][src_len[k]] = d;
    src_last[k][src_len[k]] = l;
    src_len[k]++;
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    exp_q.push_back({8'(k), d});
  endtask

  task automatic apply_src();
    for (int k = 0; k < NCH; k++) begin
      if (src_idx[k] < src_len[k]) begin
        ch_tx_valid_i[k]          = 1'b1;
        ch_tx_last_i[k]           = src_last[k][src_idx[k]];
        ch_tx_data_i[k*DW +: DW]  = src_data[k][src_idx[k]];
      end else begin
        ch_tx_valid_i[k]          = 1'b0;
        ch_tx_last_i[k]           = 1'b0;
        ch_tx_data_i[k*DW +: DW]  = 8'h00;
      end
    end
  endtask

  // One clock: note accepted words just before the edge, then advance the sources
  task automatic cycle();
    logic [NCH-1:0] hs;
    #1;
    hs = ch_tx_valid_i & ch_tx_ready_o;
    @(posedge clk_i);
    #2;
    for (int k = 0; k < NCH; k++) begin
      if (hs[k]) src_idx[k]++;
    end
    apply_src();
  endtask

  function automatic bit srcs_done(input logic [NCH-1:0] mask);
    for (int k = 0; k < NCH; k++) begin
      if (mask[k] && (src_idx[k] < src_len[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_until(input logic [NCH-1:0] mask, input int bound);
    int n;
    n = 0;
    while (!(srcs_done(mask) && (exp_q.size() == 0)) && (n < bound)) begin
      cycle();
      n++;
    end
    check("run_bound", 32'(n < bound), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},      32'(busy_o),          32'd0);
    check({tag, "_owner"},     32'(owner_o),         32'd0);
    check({tag, "_err"},       32'(err_o),           32'd0);
    check({tag, "_abort"},     32'(abort_o),         32'd0);
    check({tag, "_tx_ready"},  32'(ch_tx_ready_o),   32'd0);
    check({tag, "_rx_valid"},  32'(ch_rx_valid_o),   32'd0);
    check({tag, "_ctx_valid"}, 32'(ctrl_tx_valid_o), 32'd0);
    check({tag, "_crx_ready"}, 32'(ctrl_rx_ready_o), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    #1;
    check_reset(tag);
    clr_src();
    apply_src();
    exp_q.delete();
    rx_exp_q.delete();
    ch_en_i = 4'b1111;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic load_two_each();
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < NCH; k++) begin
        add_word(k, 8'(k*16 + t*4),     1'b0);
        add_word(k, 8'(k*16 + t*4 + 1), 1'b1);
      end
    end
  endtask

  // Engine-side scoreboard: every accepted word must be the next expected {owner, data}
  always @(negedge clk_i) begin
    if (!rst_i && ctrl_tx_valid_o && ctrl_tx_ready_i) begin
      logic [15:0] e;
      check("tx_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_owner", 32'(owner_o), 32'(e[15:8]));
        check("tx_data",  32'(ctrl_tx_data_o), 32'(e[7:0]));
      end
    end
  end

  // Channel-side RX scoreboard
  always @(negedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        if (ch_rx_valid_o[k] && ch_rx_ready_i[k]) begin
          logic [15:0] e;
          check("rx_pending", 32'(rx_exp_q.size() != 0), 32'd1);
          if (rx_exp_q.size() != 0) begin
            e = rx_exp_q.pop_front();
            check("rx_chan", 32'(k), 32'(e[15:8]));
            check("rx_data", 32'(ch_rx_data_o[k*DW +: DW]), 32'(e[7:0]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i           = 1'b1;
    ch_en_i         = 4'b1111;
    ch_tx_data_i    = '0;
    ch_tx_last_i    = '0;
    ch_tx_valid_i   = '0;
    ch_rx_ready_i   = 4'b1111;
    ctrl_tx_ready_i = 1'b1;
    ctrl_rx_data_i  = 8'h00;
    ctrl_rx_valid_i = 1'b0;
    ctrl_idle_i     = 1'b0;
    timeout_cfg_i   = 16'd0;
    err_clr_i       = 4'b0000;
    clr_src();

    // Ch1 alone, three words, engine idle four cycles after the last word
    do_reset("rst0");
    add_word(1, 8'hA0, 1'b0);
    add_word(1, 8'h10, 1'b0);
    add_word(1, 8'h55, 1'b1);
    push_exp(1, 8'hA0);
    push_exp(1, 8'h10);
    push_exp(1, 8'h55);
    apply_src();
    #1;
    check("t1_arb_no_ready", 32'(ch_tx_ready_o), 32'd0);
    check("t1_arb_no_valid", 32'(ctrl_tx_valid_o), 32'd0);
    cycle();
    check("t1_owner", 32'(owner_o), 32'd1);
    check("t1_busy_xfer", 32'(busy_o), 32'd1);
    run_until(4'b0010, 20);
    check("t1_drain_valid", 32'(ctrl_tx_valid_o), 32'd0);
    repeat (4) cycle();
    check("t1_busy_drain", 32'(busy_o), 32'd1);
    ctrl_idle_i = 1'b1;
    cycle();
    check("t1_busy_drop", 32'(busy_o), 32'd0);
    ctrl_idle_i = 1'b0;
    // rr_ptr must now be 2: ch1 and ch2 compete, ch2 must win
    ctrl_tx_ready_i = 1'b0;
    add_word(1, 8'hE1, 1'b1);
    add_word(2, 8'hE2, 1'b1);
    apply_src();
    cycle();
    check("t1_rr_ptr", 32'(owner_o), 32'd2);
    check("t1_pass_data", 32'(ctrl_tx_data_o), 32'hE2);
    check("t1_pass_ready", 32'(ch_tx_ready_o), 32'd0);
    ctrl_tx_ready_i = 1'b1;

    // All four channels, two 2-word transactions each
    do_reset("rst1");
    ctrl_idle_i = 1'b1;
    load_two_each();
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < NCH; k++) begin
        push_exp(k, 8'(k*16 + t*4));
        push_exp(k, 8'(k*16 + t*4 + 1));
      end
    end
    apply_src();
    run_until(4'b1111, 200);
    cycle();
    check("t2_idle", 32'(busy_o), 32'd0);

    // Ch2 RX routing with back-pressure in DRAIN
    do_reset("rst2");
    ctrl_idle_i = 1'b0;
    add_word(2, 8'h11, 1'b1);
    push_exp(2, 8'h11);
    apply_src();
    run_until(4'b0100, 20);
    rx_exp_q.push_back({8'd2, 8'h3C});
    rx_exp_q.push_back({8'd2, 8'h7E});
    ctrl_rx_data_i  = 8'h3C;
    ctrl_rx_valid_i = 1'b1;
    ch_rx_ready_i   = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_rx_ready_low", 32'(ctrl_rx_ready_o), 32'd0);
      check("t3_rx_valid_lane", 32'(ch_rx_valid_o), 32'h4);
      check("t3_rx_data_lane", ch_rx_data_o, 32'h003C0000);
      cycle();
    end
    ch_rx_ready_i = 4'b1111;
    #1;
    check("t3_rx_ready_high", 32'(ctrl_rx_ready_o), 32'd1);
    cycle();
    ctrl_rx_data_i = 8'h7E;
    #1;
    check("t3_rx_data2_lane", ch_rx_data_o, 32'h007E0000);
    cycle();
    ctrl_rx_valid_i = 1'b0;
    #1;
    check("t3_rx_valid_off", 32'(ch_rx_valid_o), 32'd0);
    check("t3_rx_drained", 32'(rx_exp_q.size()), 32'd0);
    ctrl_idle_i = 1'b1;
    cycle();
    ctrl_idle_i = 1'b0;
    check("t3_idle", 32'(busy_o), 32'd0);
    ctrl_rx_data_i  = 8'hFF;
    ctrl_rx_valid_i = 1'b1;
    #1;
    check("t3_stray_ready", 32'(ctrl_rx_ready_o), 32'd1);
    check("t3_stray_valid", 32'(ch_rx_valid_o), 32'd0);
    ctrl_rx_valid_i = 1'b0;

    // Ch3 stalls after one non-last word with a 5-cycle limit
    do_reset("rst3");
    timeout_cfg_i = 16'd5;
    add_word(3, 8'h99, 1'b0);
    push_exp(3, 8'h99);
    apply_src();
    run_until(4'b1000, 20);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t4_no_abort_early", 32'(abort_o), 32'd0);
    end
    cycle();
`ifdef UDMA_I2C_MUX_TIMEOUT_EN
    check("t4_abort", 32'(abort_o), 32'd1);
    check("t4_err_set", 32'(err_o), 32'h8);
    check("t4_busy_drain", 32'(busy_o), 32'd1);
    cycle();
    check("t4_abort_once", 32'(abort_o), 32'd0);
    check("t4_err_sticky", 32'(err_o), 32'h8);
    err_clr_i = 4'b1000;
    cycle();
    err_clr_i = 4'b0000;
    check("t4_err_clr", 32'(err_o), 32'd0);
    ctrl_idle_i = 1'b1;
    cycle();
    ctrl_idle_i = 1'b0;
    check("t4_idle", 32'(busy_o), 32'd0);
`else
    check("t4_abort_off", 32'(abort_o), 32'd0);
    check("t4_err_off", 32'(err_o), 32'd0);
    check("t4_still_xfer", 32'(busy_o), 32'd1);
    add_word(3, 8'h9A, 1'b1);
    push_exp(3, 8'h9A);
    apply_src();
    run_until(4'b1000, 20);
    ctrl_idle_i = 1'b1;
    cycle();
    ctrl_idle_i = 1'b0;
`endif
    timeout_cfg_i = 16'd0;
    add_word(3, 8'h98, 1'b0);
    push_exp(3, 8'h98);
    apply_src();
    run_until(4'b1000, 20);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t4_cfg0_abort", 32'(abort_o), 32'd0);
    end
    check("t4_cfg0_err", 32'(err_o), 32'd0);
    check("t4_cfg0_busy", 32'(busy_o), 32'd1);
    add_word(3, 8'h9B, 1'b1);
    push_exp(3, 8'h9B);
    apply_src();
    run_until(4'b1000, 20);
    ctrl_idle_i = 1'b1;
    cycle();
    ctrl_idle_i = 1'b0;
    check("t4_cfg0_idle", 32'(busy_o), 32'd0);

    // Only channels 1 and 3 enabled, all four valid
    do_reset("rst4");
    ctrl_idle_i = 1'b1;
    ch_en_i     = 4'b1010;
    load_two_each();
    for (int t = 0; t < 2; t++) begin
      push_exp(1, 8'(16 + t*4));
      push_exp(1, 8'(16 + t*4 + 1));
      push_exp(3, 8'(48 + t*4));
      push_exp(3, 8'(48 + t*4 + 1));
    end
    apply_src();
    run_until(4'b1010, 200);
    cycle();
    cycle();
    check("t5_no_grant", 32'(busy_o), 32'd0);

    // Reset in the middle of a ch0 transaction, then re-arbitration from IDLE
    do_reset("rst5");
    ctrl_idle_i = 1'b0;
    add_word(0, 8'h01, 1'b0);
    add_word(0, 8'h02, 1'b0);
    add_word(0, 8'h03, 1'b1);
    push_exp(0, 8'h01);
    apply_src();
    cycle();
    cycle();
    check("t6_mid_xfer", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_reset("t6_rst");
    check("t6_one_word", 32'(exp_q.size()), 32'd0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    src_idx[0] = 0;
    push_exp(0, 8'h01);
    push_exp(0, 8'h02);
    push_exp(0, 8'h03);
    apply_src();
    #1;
    check("t6_idle_after", 32'(busy_o), 32'd0);
    cycle();
    check("t6_regrant_owner", 32'(owner_o), 32'd0);
    check("t6_regrant_busy", 32'(busy_o), 32'd1);
    ctrl_idle_i = 1'b1;
    run_until(4'b0001, 20);
    cycle();
    check("t6_done", 32'(busy_o), 32'd0);

    check("final_txq", 32'(exp_q.size()), 32'd0);
    check("final_rxq", 32'(rx_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
